// File: rtl/rv_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU state encoding,
// and the small combinational helpers the LSU uses at acceptance and issue.
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = F3_LB;
  localparam logic [2:0] F3_SH  = F3_LH;
  localparam logic [2:0] F3_SW  = F3_LW;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Illegal width code for the op kind, or an address not aligned to the access size.
  function automatic logic op_err(input logic is_store, input logic [2:0] f3,
                                  input logic [1:0] off);
    logic legal;
    logic misaligned;
    case (f3)
      F3_LB, F3_LH, F3_LW: legal = 1'b1;
      F3_LBU, F3_LHU:      legal = ~is_store;
      default:             legal = 1'b0;
    endcase
    case (f3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return ~legal | misaligned;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_SB:   return 4'b0001 << off;
      F3_SH:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the narrow datum puts it in every lane the byte enables can select.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      F3_SB:   return {4{data[7:0]}};
      F3_SH:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module lsu_load_fmt
  import rv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LHU:  data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: accepts one op at a time, issues a single word-aligned
// memory request, formats load data and reports completion with a one-cycle pulse.
module lsu
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        done_valid,
  output logic        done_err,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_we
);

  lsu_state_e  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        err_q, err_d;
  logic [31:0] ldata_q, ldata_d;
  logic [31:0] fmt_data;
  logic        accept;
  logic        is_load_ok;

  lsu_load_fmt u_load_fmt (
    .rdata  (mem_rdata),
    .addr   (addr_q[1:0]),
    .funct3 (funct3_q),
    .data   (fmt_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  // Op fields are only observed through state-qualified outputs, so they need no reset.
  always_ff @(posedge clk) begin
    is_store_q <= is_store_d;
    funct3_q   <= funct3_d;
    addr_q     <= addr_d;
    wdata_q    <= wdata_d;
    rd_q       <= rd_d;
    err_q      <= err_d;
    ldata_q    <= ldata_d;
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    err_d      = err_q;
    ldata_d    = ldata_q;
    accept     = req_valid && req_ready;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rd_d       = req_rd;
          err_d      = op_err(req_is_store, req_funct3, req_addr[1:0]);
          state_d    = err_d ? LSU_DONE : LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (mem_req_ready) state_d = is_store_q ? LSU_DONE : LSU_WAIT;
      end
      LSU_WAIT: begin
        if (mem_rsp_valid) begin
          ldata_d = fmt_data;
          state_d = LSU_DONE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    is_load_ok    = (state_q == LSU_DONE) && !err_q && !is_store_q;
    req_ready     = (state_q == LSU_IDLE) && rst_n;
    mem_req_valid = (state_q == LSU_REQ);
    mem_addr      = mem_req_valid ? {addr_q[31:2], 2'b00} : 32'h0;
    mem_we        = mem_req_valid && is_store_q;
    mem_be        = mem_we ? store_be(funct3_q, addr_q[1:0]) : 4'h0;
    mem_wdata     = mem_we ? store_lanes(funct3_q, wdata_q) : 32'h0;
    done_valid    = (state_q == LSU_DONE);
    done_err      = done_valid && err_q;
    wb_rd         = is_load_ok ? rd_q : 5'd0;
    wb_data       = is_load_ok ? ldata_q : 32'h0;
    wb_we         = is_load_ok && (rd_q != 5'd0);
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, hand-built stall/reset
// sequences and randomized ops compared against an arithmetic reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid;
  logic        done_valid, done_err, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .done_valid(done_valid), .done_err(done_err), .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          err;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] lanes;
    logic [31:0] mask;
    bit          wbwe;
    logic [31:0] wbdata;
    logic [4:0]  wbrd;
    int          lat;
  } exp_t;

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    bit          x_err;
    logic [3:0]  x_be;
    logic [31:0] x_wbdata;
    bit          x_wbwe;
  } vec_t;

  // Observations from the most recent run_op
  bit          o_seen_req, o_timeout, o_err, o_wbwe, o_we;
  logic [31:0] o_addr, o_wdata, o_wbdata;
  logic [3:0]  o_be;
  logic [4:0]  o_wbrd;
  int          o_lat, o_unstable, o_rdy_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from the access-size / alignment / lane rules.
  function automatic exp_t model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [4:0] rd,
                                 input logic [31:0] rdata, input int stall, input int delay);
    exp_t e;
    int size, off;
    bit sgn;
    longint v;
    size = 0; sgn = 0;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: size = st ? 0 : 1;
      3'd5: size = st ? 0 : 2;
      default: size = 0;
    endcase
    off = int'(addr % 4);
    e.err = (size == 0) || ((addr % size) != 0);
    e.maddr = addr - (addr % 4);
    e.be = 4'h0; e.mask = 32'h0; e.lanes = 32'h0;
    if (!e.err && st) begin
      for (int i = 0; i < size; i++) begin
        e.be[off + i] = 1'b1;
        e.mask[8*(off+i) +: 8] = 8'hFF;
      end
      e.lanes = (wd << (8*off)) & e.mask;
    end
    v = 0;
    if (!e.err && !st) begin
      v = (longint'(rdata) >> (8*off)) & ((64'd1 << (8*size)) - 1);
      if (sgn && size < 4 && v >= (64'd1 << (8*size - 1))) v = v - (64'd1 << (8*size));
    end
    e.wbdata = v[31:0];
    e.wbwe = !e.err && !st && (rd != 0);
    e.wbrd = rd;
    e.lat = e.err ? 1 : (st ? 2 + stall : 3 + stall + delay);
    return e;
  endfunction

  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                        input int stall, input int delay, input bit junk);
    int scnt, wcnt;
    bit hs, hs_now;
    scnt = 0; wcnt = 0; hs = 0;
    o_seen_req = 0; o_timeout = 1; o_unstable = 0; o_rdy_busy = 0; o_lat = 0;
    o_err = 0; o_wbwe = 0; o_wbdata = 0; o_wbrd = 0;
    o_addr = 0; o_be = 0; o_we = 0; o_wdata = 0;
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1; req_is_store = st; req_funct3 = f3; req_addr = addr;
    req_wdata = wd; req_rd = rd; mem_req_ready = 0; mem_rsp_valid = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      req_valid = 0; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
      if (done_valid) begin
        o_lat = cyc; o_err = done_err; o_wbwe = wb_we; o_wbdata = wb_data; o_wbrd = wb_rd;
        o_timeout = 0; mem_req_ready = 0; mem_rsp_valid = 0;
        break;
      end
      if (req_ready) o_rdy_busy++;
      hs_now = hs;
      mem_rsp_valid = 0; mem_rdata = $urandom; mem_req_ready = 0;
      if (mem_req_valid) begin
        if (!o_seen_req) begin
          o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wdata = mem_wdata;
        end else if (o_addr !== mem_addr || o_be !== mem_be || o_we !== mem_we ||
                     o_wdata !== mem_wdata) o_unstable++;
        o_seen_req = 1;
        mem_req_ready = (scnt >= stall);
        scnt++;
        if (mem_req_ready) hs = 1;
      end else if (hs_now) begin
        if (wcnt == delay) begin mem_rsp_valid = 1; mem_rdata = rdata; end
        wcnt++;
      end
      if (!hs_now && junk) mem_rsp_valid = 1;
    end
    chk("done_seen", {31'b0, ~o_timeout}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done_valid}, 32'd0);
    chk("ready_after_done", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic check_model(input string tag, input exp_t e);
    chk({tag, "_err"}, {31'b0, o_err}, {31'b0, e.err});
    chk({tag, "_lat"}, o_lat, e.lat);
    chk({tag, "_memreq"}, {31'b0, o_seen_req}, {31'b0, ~e.err});
    chk({tag, "_busy_ready"}, o_rdy_busy, 0);
    chk({tag, "_stable"}, o_unstable, 0);
    if (!e.err) begin
      chk({tag, "_maddr"}, o_addr, e.maddr);
      chk({tag, "_be"}, {28'b0, o_be}, {28'b0, e.be});
      chk({tag, "_we"}, {31'b0, o_we}, {31'b0, e.be != 4'h0});
      chk({tag, "_wdata"}, o_wdata & e.mask, e.lanes);
    end
    chk({tag, "_wbwe"}, {31'b0, o_wbwe}, {31'b0, e.wbwe});
    chk({tag, "_wbdata"}, o_wbdata, e.wbdata);
    if (e.wbwe) chk({tag, "_wbrd"}, {27'b0, o_wbrd}, {27'b0, e.wbrd});
  endtask

  vec_t vecs[13];
  exp_t e;

  initial begin
    rst_n = 0; req_valid = 0; req_is_store = 0; req_funct3 = 0; req_addr = 0;
    req_wdata = 0; req_rd = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
    #1;
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_done_valid", {31'b0, done_valid}, 32'd0);
    chk("rst_be_we", {27'b0, mem_be, mem_we}, 32'd0);
    chk("rst_wb", {26'b0, wb_we, wb_rd} | wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 chk("rst_release_ready", {31'b0, req_ready}, 32'd1);

    //         st  f3     addr          wdata         rd    rdata         err be     wbdata        wbwe
    vecs[0]  = '{1, 3'd2, 32'h0000_0100, 32'hDEADBEEF, 5'd0, 32'h0,        0, 4'hF, 32'h0,        0};
    vecs[1]  = '{1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 5'd0, 32'h0,       0, 4'h8, 32'h0,        0};
    vecs[2]  = '{0, 3'd0, 32'h0000_0102, 32'h0,        5'd5, 32'h12F03456, 0, 4'h0, 32'hFFFFFFF0, 1};
    vecs[3]  = '{0, 3'd4, 32'h0000_0102, 32'h0,        5'd5, 32'h12F03456, 0, 4'h0, 32'h000000F0, 1};
    vecs[4]  = '{0, 3'd1, 32'h0000_0101, 32'h0,        5'd3, 32'h11223344, 1, 4'h0, 32'h0,        0};
    vecs[5]  = '{0, 3'd3, 32'h0000_0100, 32'h0,        5'd3, 32'h11223344, 1, 4'h0, 32'h0,        0};
    vecs[6]  = '{1, 3'd4, 32'h0000_0104, 32'h55,       5'd0, 32'h0,        1, 4'h0, 32'h0,        0};
    vecs[7]  = '{1, 3'd1, 32'h0000_0102, 32'h1234BEEF, 5'd0, 32'h0,        0, 4'hC, 32'h0,        0};
    vecs[8]  = '{0, 3'd1, 32'h0000_0102, 32'h0,        5'd7, 32'h80010000, 0, 4'h0, 32'hFFFF8001, 1};
    vecs[9]  = '{0, 3'd5, 32'h0000_0102, 32'h0,        5'd7, 32'h80010000, 0, 4'h0, 32'h00008001, 1};
    vecs[10] = '{0, 3'd2, 32'h0000_0204, 32'h0,        5'd0, 32'hCAFEF00D, 0, 4'h0, 32'hCAFEF00D, 0};
    vecs[11] = '{0, 3'd2, 32'h0000_0201, 32'h0,        5'd9, 32'hCAFEF00D, 1, 4'h0, 32'h0,        0};
    vecs[12] = '{1, 3'd2, 32'h0000_0102, 32'h77,       5'd0, 32'h0,        1, 4'h0, 32'h0,        0};

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].rdata, 0, 0, 1);
      chk($sformatf("vec%0d_err", i), {31'b0, o_err}, {31'b0, vecs[i].x_err});
      chk($sformatf("vec%0d_be", i), {28'b0, o_be}, {28'b0, vecs[i].x_be});
      chk($sformatf("vec%0d_wbdata", i), o_wbdata, vecs[i].x_wbdata);
      chk($sformatf("vec%0d_wbwe", i), {31'b0, o_wbwe}, {31'b0, vecs[i].x_wbwe});
      e = model(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].rdata, 0, 0);
      check_model($sformatf("vec%0d", i), e);
    end

    // LW with the memory stalling three cycles, then a two-cycle response delay
    run_op(0, 3'd2, 32'h0000_0200, 32'h0, 5'd12, 32'hA5A5_1234, 3, 2, 0);
    chk("stall_stable", o_unstable, 0);
    chk("stall_ready_low", o_rdy_busy, 0);
    chk("stall_lat", o_lat, 8);
    chk("stall_wbdata", o_wbdata, 32'hA5A5_1234);
    chk("stall_maddr", o_addr, 32'h0000_0200);

    // Reset while waiting for read data; a late response must not complete anything
    @(negedge clk);
    req_valid = 1; req_is_store = 0; req_funct3 = 3'd2; req_addr = 32'h300; req_rd = 5'd4;
    @(negedge clk);
    req_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_wait_outputs", {29'b0, done_valid, mem_req_valid, wb_we}, 32'd0);
    @(negedge clk);
    rst_n = 1; mem_rsp_valid = 1; mem_rdata = 32'h1357_9BDF;
    o_lat = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done_valid) o_lat++;
    end
    mem_rsp_valid = 0;
    chk("rst_wait_no_done", o_lat, 0);
    chk("rst_wait_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_wait_no_req", {31'b0, mem_req_valid}, 32'd0);

    for (int n = 0; n < 150; n++) begin
      bit st;
      logic [2:0] f3;
      logic [31:0] addr, wd, rdata;
      logic [4:0] rd;
      int stall, delay;
      st = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wd = $urandom;
      rdata = $urandom; rd = 5'($urandom); stall = $urandom_range(0, 2); delay = $urandom_range(0, 2);
      run_op(st, f3, addr, wd, rd, rdata, stall, delay, 1'($urandom));
      e = model(st, f3, addr, wd, rd, rdata, stall, delay);
      check_model($sformatf("rnd%0d", n), e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The module SHALL have a single clock `clk` and an asynchronous, active-low reset `rst_n`; the polarity and synchronicity are fixed.
REQ-002 Port list (name, direction, width, meaning), clock and reset first:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: execute stage presents a memory op.
- `req_ready` out 1: LSU can accept an op; high only in IDLE.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign code.
- `req_addr` in 32: byte address, taken from the ALU result.
- `req_wdata` in 32: store data (rs2).
- `req_rd` in 5: load destination register.
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_addr` out 32: word address, `{req_addr[31:2],2'b00}`.
- `mem_we` out 1: write enable.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-shifted store data.
- `mem_rsp_valid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `done_valid` out 1: one-cycle completion pulse.
- `done_err` out 1: misaligned or illegal op; qualified by `done_valid`.
- `wb_rd` out 5: load destination register.
- `wb_data` out 32: formatted load data; 0 for stores and errors.
- `wb_we` out 1: register-file write strobe.

Function
REQ-003 The LSU SHALL implement the FSM IDLE -> REQ -> WAIT (loads only) -> DONE -> IDLE, plus the path IDLE -> DONE for errors.
REQ-004 An op SHALL be accepted on a cycle where `req_valid && req_ready`; all request fields SHALL be registered at acceptance.
REQ-005 Legal loads: LB=000, LH=001, LW=010, LBU=100, LHU=101. Legal stores: SB=000, SH=001, SW=010. Any other `req_funct3` SHALL be illegal.
REQ-006 The alignment rules SHALL be:
- H accesses require `addr[0]=0`.
- W accesses require `addr[1:0]=00`.
- B accesses are always aligned.
REQ-007 An illegal or misaligned op SHALL go IDLE -> DONE with `done_err=1`, `wb_we=0`, and no memory request issued.
REQ-008 In REQ, `mem_req_valid` SHALL be 1 and all `mem_*` request outputs SHALL be held stable until `mem_req_ready`.
REQ-009 On the `mem_req_ready` handshake in REQ:
- a store SHALL go to DONE;
- a load SHALL go to WAIT.
REQ-010 `mem_be` SHALL be:
- SB: `4'b0001 << addr[1:0]`;
- SH: `4'b0011 << addr[1:0]`;
- SW: `4'b1111`;
- loads: 0.
REQ-011 `mem_wdata` SHALL be the store data replicated or shifted into the addressed lane(s); `mem_we` SHALL be 1 for stores only.
REQ-012 In WAIT, `mem_rsp_valid` SHALL capture `mem_rdata`.
- The addressed byte or halfword SHALL be extracted using `addr[1:0]`.
- LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend.
- The state SHALL then go to DONE.
REQ-013 DONE SHALL last exactly one cycle and drive `done_valid=1`.
- For a load without error: `wb_we=1`, plus `wb_rd` and `wb_data`.
- For a load with `rd=0`: `wb_we=0`.
REQ-014 `mem_rsp_valid` SHALL be ignored outside WAIT.
REQ-015 `req_ready` SHALL be 0 in REQ, WAIT and DONE; there SHALL be no back-to-back acceptance in DONE.
REQ-016 Latency from acceptance to `done_valid`, counted in cycles after acceptance:
- store with `mem_req_ready` held high: 2;
- load with a zero-wait response: 3;
- error: 1.

Reset
REQ-017 Asserting `rst_n=0` SHALL immediately force:
- state to IDLE;
- `req_ready=1` once reset is released;
- all other outputs to 0.
REQ-018 A reset during REQ or WAIT SHALL abandon the op; no `done_valid` SHALL be produced for it, and any later stale `mem_rsp_valid` SHALL be ignored.

Structure
REQ-019 The funct3 load/store constants and the LSU state enum SHALL live in the shared package `rv_pkg`.
REQ-020 Load extraction and sign extension SHALL be a combinational sub-module `lsu_load_fmt` (inputs: `rdata`, `addr[1:0]`, `funct3`; output: 32-bit data).

Verification
REQ-021 SW to addr 0x100 with data 0xDEADBEEF and `mem_req_ready=1` -> `mem_addr=0x100`, `be=1111`, `wdata=0xDEADBEEF`, `done_valid` 2 cycles after acceptance, `err=0`.
REQ-022 SB to addr 0x103 with data 0x000000A5 -> `be=1000`, `wdata[31:24]=0xA5`.
REQ-023 LB from 0x102 with `rdata=0x12F0_3456`, `rd=5` -> `wb_data=0xFFFFFFF0`, `wb_rd=5`, `wb_we=1`; the same access as LBU -> `0x000000F0`.
REQ-024 LH at 0x101 -> `done_err=1` one cycle after acceptance, `mem_req_valid` never asserted; `funct3=011` load -> `done_err=1`.
REQ-025 LW at 0x200 with `mem_req_ready` held low 3 cycles -> request outputs stable throughout, `req_ready=0`; a response after 2 cycles -> `wb_data=rdata`.
REQ-026 `rst_n` pulsed low while in WAIT, followed by `mem_rsp_valid=1` -> no `done_valid`, state IDLE, `req_ready=1`.
